// File: rtl/instr_encode.sv
// RV32I instruction encoder: turns an instruction description into a 32-bit machine word
// through a two-stage valid/ready pipeline, tagging each word with its instruction-memory index.
package instr_encode_pkg;
  localparam int REGISTER_DESCRIPTOR_WIDTH = 5;

  typedef enum logic [5:0] {
    INSTR_INVALID = 6'd0,
    INSTR_LUI, INSTR_AUIPC, INSTR_JAL, INSTR_JALR,
    INSTR_BEQ, INSTR_BNE, INSTR_BLT, INSTR_BGE, INSTR_BLTU, INSTR_BGEU,
    INSTR_LB, INSTR_LH, INSTR_LW, INSTR_LBU, INSTR_LHU,
    INSTR_SB, INSTR_SH, INSTR_SW,
    INSTR_ADDI, INSTR_SLTI, INSTR_SLTIU, INSTR_XORI, INSTR_ORI, INSTR_ANDI,
    INSTR_SLLI, INSTR_SRLI, INSTR_SRAI,
    INSTR_ADD, INSTR_SUB, INSTR_SLL, INSTR_SLT, INSTR_SLTU,
    INSTR_XOR, INSTR_SRL, INSTR_SRA, INSTR_OR, INSTR_AND,
    INSTR_FENCE, INSTR_FENCE_I, INSTR_ECALL, INSTR_EBREAK,
    INSTR_CSRRW, INSTR_CSRRS, INSTR_CSRRC, INSTR_CSRRWI, INSTR_CSRRSI, INSTR_CSRRCI
  } instr_kind_t;
endpackage

module instr_encode
  import instr_encode_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          ERR_WIDTH  = 8,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 clear,
  input  logic                                 req_valid,
  output logic                                 req_ready,
  input  instr_kind_t                          req_kind,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] req_rd,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] req_rs1,
  input  logic [REGISTER_DESCRIPTOR_WIDTH-1:0] req_rs2,
  input  logic [31:0]                          req_imm,
  input  logic [11:0]                          req_csr,
  input  logic [3:0]                           req_pred,
  input  logic [3:0]                           req_succ,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [31:0]                          out_word,
  output logic                                 out_err,
  output logic [ADDR_WIDTH-1:0]                out_addr,
  output logic [ERR_WIDTH-1:0]                 err_count
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_MISC   = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] F7_ALT    = 7'b0100000;

  // Shifts-by-immediate share the R layout (shamt sits in the rs2 slot); CSR*I share CSR (zimm in rs1).
  typedef enum logic [3:0] {
    FMT_R, FMT_I, FMT_S, FMT_B, FMT_J, FMT_U, FMT_FENCE, FMT_CSR, FMT_FIXED, FMT_BAD
  } fmt_e;

  localparam int RW = REGISTER_DESCRIPTOR_WIDTH;

  logic              s1_valid_q, s1_valid_d;
  instr_kind_t       s1_kind_q;
  logic [RW-1:0]     s1_rd_q, s1_rs1_q, s1_rs2_q;
  logic [31:0]       s1_imm_q;
  logic [11:0]       s1_csr_q;
  logic [3:0]        s1_pred_q, s1_succ_q;

  logic              s2_valid_q, s2_valid_d;
  logic [31:0]       s2_word_q, s2_word_d;
  logic              s2_err_q, s2_err_d;
  logic [ADDR_WIDTH-1:0] out_addr_q, out_addr_d;
  logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;

  logic s2_ready, s1_adv, req_fire, out_fire;

  fmt_e        fmt;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [31:0] fixed_word, enc_word;
  logic        ok_i, ok_b, ok_j, ok_u;

  // Handshake: req_ready looks only at occupancy, out_ready and clear, never at req_valid.
  always_comb begin
    s2_ready  = !s2_valid_q || out_ready;
    s1_adv    = s1_valid_q && s2_ready;
    req_ready = (!s1_valid_q || s2_ready) && !clear;
    req_fire  = req_valid && req_ready;
    out_fire  = s2_valid_q && out_ready;

    s1_valid_d  = clear ? 1'b0 : (req_fire || (s1_valid_q && !s1_adv));
    s2_valid_d  = clear ? 1'b0 : (s1_adv || (s2_valid_q && !out_ready));
    out_addr_d  = clear ? '0 : (out_fire ? out_addr_q + ADDR_WIDTH'(1) : out_addr_q);
    err_count_d = err_count_q;
    if (clear) begin
      err_count_d = '0;
    end else if (out_fire && s2_err_q && (err_count_q != '1)) begin
      err_count_d = err_count_q + ERR_WIDTH'(1);
    end
  end

  // NOTE: every variable written here gets a default before the case so no latch is inferred.
  always_comb begin
    fmt        = FMT_BAD;
    opcode     = '0;
    funct3     = '0;
    funct7     = '0;
    fixed_word = '0;
    case (s1_kind_q)
      INSTR_LUI:     begin fmt = FMT_U; opcode = OP_LUI;   end
      INSTR_AUIPC:   begin fmt = FMT_U; opcode = OP_AUIPC; end
      INSTR_JAL:     begin fmt = FMT_J; opcode = OP_JAL;   end
      INSTR_JALR:    begin fmt = FMT_I; opcode = OP_JALR;  end
      INSTR_BEQ:     begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = 3'b000; end
      INSTR_BNE:     begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = 3'b001; end
      INSTR_BLT:     begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = 3'b100; end
      INSTR_BGE:     begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = 3'b101; end
      INSTR_BLTU:    begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = 3'b110; end
      INSTR_BGEU:    begin fmt = FMT_B; opcode = OP_BRANCH; funct3 = 3'b111; end
      INSTR_LB:      begin fmt = FMT_I; opcode = OP_LOAD;  funct3 = 3'b000; end
      INSTR_LH:      begin fmt = FMT_I; opcode = OP_LOAD;  funct3 = 3'b001; end
      INSTR_LW:      begin fmt = FMT_I; opcode = OP_LOAD;  funct3 = 3'b010; end
      INSTR_LBU:     begin fmt = FMT_I; opcode = OP_LOAD;  funct3 = 3'b100; end
      INSTR_LHU:     begin fmt = FMT_I; opcode = OP_LOAD;  funct3 = 3'b101; end
      INSTR_SB:      begin fmt = FMT_S; opcode = OP_STORE; funct3 = 3'b000; end
      INSTR_SH:      begin fmt = FMT_S; opcode = OP_STORE; funct3 = 3'b001; end
      INSTR_SW:      begin fmt = FMT_S; opcode = OP_STORE; funct3 = 3'b010; end
      INSTR_ADDI:    begin fmt = FMT_I; opcode = OP_IMM;   funct3 = 3'b000; end
      INSTR_SLTI:    begin fmt = FMT_I; opcode = OP_IMM;   funct3 = 3'b010; end
      INSTR_SLTIU:   begin fmt = FMT_I; opcode = OP_IMM;   funct3 = 3'b011; end
      INSTR_XORI:    begin fmt = FMT_I; opcode = OP_IMM;   funct3 = 3'b100; end
      INSTR_ORI:     begin fmt = FMT_I; opcode = OP_IMM;   funct3 = 3'b110; end
      INSTR_ANDI:    begin fmt = FMT_I; opcode = OP_IMM;   funct3 = 3'b111; end
      INSTR_SLLI:    begin fmt = FMT_R; opcode = OP_IMM;   funct3 = 3'b001; end
      INSTR_SRLI:    begin fmt = FMT_R; opcode = OP_IMM;   funct3 = 3'b101; end
      INSTR_SRAI:    begin fmt = FMT_R; opcode = OP_IMM;   funct3 = 3'b101; funct7 = F7_ALT; end
      INSTR_ADD:     begin fmt = FMT_R; opcode = OP_REG;   funct3 = 3'b000; end
      INSTR_SUB:     begin fmt = FMT_R; opcode = OP_REG;   funct3 = 3'b000; funct7 = F7_ALT; end
      INSTR_SLL:     begin fmt = FMT_R; opcode = OP_REG;   funct3 = 3'b001; end
      INSTR_SLT:     begin fmt = FMT_R; opcode = OP_REG;   funct3 = 3'b010; end
      INSTR_SLTU:    begin fmt = FMT_R; opcode = OP_REG;   funct3 = 3'b011; end
      INSTR_XOR:     begin fmt = FMT_R; opcode = OP_REG;   funct3 = 3'b100; end
      INSTR_SRL:     begin fmt = FMT_R; opcode = OP_REG;   funct3 = 3'b101; end
      INSTR_SRA:     begin fmt = FMT_R; opcode = OP_REG;   funct3 = 3'b101; funct7 = F7_ALT; end
      INSTR_OR:      begin fmt = FMT_R; opcode = OP_REG;   funct3 = 3'b110; end
      INSTR_AND:     begin fmt = FMT_R; opcode = OP_REG;   funct3 = 3'b111; end
      INSTR_FENCE:   begin fmt = FMT_FENCE; opcode = OP_MISC; end
      INSTR_FENCE_I: begin fmt = FMT_FIXED; fixed_word = 32'h0000_100F; end
      INSTR_ECALL:   begin fmt = FMT_FIXED; fixed_word = 32'h0000_0073; end
      INSTR_EBREAK:  begin fmt = FMT_FIXED; fixed_word = 32'h0010_0073; end
      INSTR_CSRRW:   begin fmt = FMT_CSR; opcode = OP_SYSTEM; funct3 = 3'b001; end
      INSTR_CSRRS:   begin fmt = FMT_CSR; opcode = OP_SYSTEM; funct3 = 3'b010; end
      INSTR_CSRRC:   begin fmt = FMT_CSR; opcode = OP_SYSTEM; funct3 = 3'b011; end
      INSTR_CSRRWI:  begin fmt = FMT_CSR; opcode = OP_SYSTEM; funct3 = 3'b101; end
      INSTR_CSRRSI:  begin fmt = FMT_CSR; opcode = OP_SYSTEM; funct3 = 3'b110; end
      INSTR_CSRRCI:  begin fmt = FMT_CSR; opcode = OP_SYSTEM; funct3 = 3'b111; end
      default:       fmt = FMT_BAD;
    endcase
  end

  // Range checks: the bits above each field must be a pure sign extension of it.
  always_comb begin
    ok_i = (s1_imm_q[31:11] == '0) || (s1_imm_q[31:11] == '1);
    ok_b = ((s1_imm_q[31:12] == '0) || (s1_imm_q[31:12] == '1)) && !s1_imm_q[0];
    ok_j = ((s1_imm_q[31:20] == '0) || (s1_imm_q[31:20] == '1)) && !s1_imm_q[0];
    ok_u = (s1_imm_q[31:20] == '0);

    enc_word = '0;
    s2_err_d = 1'b0;
    case (fmt)
      FMT_R: enc_word = {funct7, s1_rs2_q, s1_rs1_q, funct3, s1_rd_q, opcode};
      FMT_I: begin
        enc_word = {s1_imm_q[11:0], s1_rs1_q, funct3, s1_rd_q, opcode};
        s2_err_d = !ok_i;
      end
      FMT_S: begin
        enc_word = {s1_imm_q[11:5], s1_rs2_q, s1_rs1_q, funct3, s1_imm_q[4:0], opcode};
        s2_err_d = !ok_i;
      end
      FMT_B: begin
        enc_word = {s1_imm_q[12], s1_imm_q[10:5], s1_rs2_q, s1_rs1_q, funct3,
                    s1_imm_q[4:1], s1_imm_q[11], opcode};
        s2_err_d = !ok_b;
      end
      FMT_J: begin
        enc_word = {s1_imm_q[20], s1_imm_q[10:1], s1_imm_q[11], s1_imm_q[19:12], s1_rd_q, opcode};
        s2_err_d = !ok_j;
      end
      FMT_U: begin
        enc_word = {s1_imm_q[19:0], s1_rd_q, opcode};
        s2_err_d = !ok_u;
      end
      FMT_FENCE: enc_word = {4'b0000, s1_pred_q, s1_succ_q, 5'd0, 3'b000, 5'd0, opcode};
      FMT_CSR:   enc_word = {s1_csr_q, s1_rs1_q, funct3, s1_rd_q, opcode};
      FMT_FIXED: enc_word = fixed_word;
      default:   s2_err_d = 1'b1;
    endcase
    s2_word_d = s2_err_d ? NOP_WORD : enc_word;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_word_q   <= '0;
      s2_err_q    <= 1'b0;
      out_addr_q  <= '0;
      err_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s2_valid_q  <= s2_valid_d;
      out_addr_q  <= out_addr_d;
      err_count_q <= err_count_d;
      if (s1_adv && !clear) begin
        s2_word_q <= s2_word_d;
        s2_err_q  <= s2_err_d;
      end
    end
  end

  // NOTE: the S1 payload is qualified by s1_valid_q, so it needs no reset and saves reset routing.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      s1_kind_q <= req_kind;
      s1_rd_q   <= req_rd;
      s1_rs1_q  <= req_rs1;
      s1_rs2_q  <= req_rs2;
      s1_imm_q  <= req_imm;
      s1_csr_q  <= req_csr;
      s1_pred_q <= req_pred;
      s1_succ_q <= req_succ;
    end
  end

  assign out_valid = s2_valid_q;
  assign out_word  = s2_word_q;
  assign out_err   = s2_err_q;
  assign out_addr  = out_addr_q;
  assign err_count = err_count_q;

endmodule

// File: tb/tb_instr_encode.sv
// Directed testbench for instr_encode: hand-computed RV32I words, errors, back-pressure,
// reset and clear behaviour, error-count saturation and address wrap.
module tb_instr_encode;
  import instr_encode_pkg::*;

  localparam int AW = 10;
  localparam int EW = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst, clear, req_valid, req_ready, out_valid, out_ready, out_err;
  instr_kind_t req_kind;
  logic [4:0]  req_rd, req_rs1, req_rs2;
  logic [31:0] req_imm, out_word;
  logic [11:0] req_csr;
  logic [3:0]  req_pred, req_succ;
  logic [AW-1:0] out_addr;
  logic [EW-1:0] err_count;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    instr_kind_t kind;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [11:0] csr;
    logic [3:0]  pred, succ;
    logic [31:0] word;
    logic        err;
  } vec_t;

  instr_encode #(.ADDR_WIDTH(AW), .ERR_WIDTH(EW), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
    .req_rd(req_rd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .req_csr(req_csr), .req_pred(req_pred), .req_succ(req_succ),
    .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
    .out_err(out_err), .out_addr(out_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(instr_kind_t k, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                              logic [31:0] imm, logic [11:0] csr, logic [3:0] pred,
                              logic [3:0] succ, logic [31:0] word, logic err);
    vec_t v;
    v.kind = k; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
    v.csr = csr; v.pred = pred; v.succ = succ; v.word = word; v.err = err;
    return v;
  endfunction

  task automatic set_req(input vec_t v);
    req_kind = v.kind; req_rd = v.rd; req_rs1 = v.rs1; req_rs2 = v.rs2;
    req_imm = v.imm; req_csr = v.csr; req_pred = v.pred; req_succ = v.succ;
  endtask

  // Offers one request and returns once it has been accepted (or the budget ran out).
  task automatic issue(input vec_t v, output bit timeout);
    @(negedge clk);
    set_req(v);
    req_valid = 1'b1;
    timeout = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin timeout = 1'b0; break; end
      @(negedge clk);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  // Waits for the next output word with out_ready high; cycles counts negedges until it showed.
  task automatic wait_out(output logic [31:0] w, output logic e, output logic [AW-1:0] a,
                          output int cycles, output bit timeout);
    timeout = 1'b1; cycles = 0; w = '0; e = 1'b0; a = '0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        w = out_word; e = out_err; a = out_addr; cycles = i; timeout = 1'b0;
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vectors++;
    if ({out_valid, out_err, out_word, out_addr, err_count} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got valid=%b err=%b word=%h addr=%0d cnt=%0d expected all zero",
               out_valid, out_err, out_word, out_addr, err_count);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_req_ready: got %b expected 1", req_ready);
    end
  endtask

  task automatic test_single();
    logic [31:0] w; logic e; logic [AW-1:0] a; int cyc; bit to;
    out_ready = 1'b1;
    issue(mk(INSTR_ADDI, 5'd1, 5'd0, 5'd0, 32'd5, 12'h0, 4'h0, 4'h0, 32'h0, 1'b0), to);
    wait_out(w, e, a, cyc, to);
    vectors++;
    if (to || w !== 32'h0050_0093 || e !== 1'b0 || a !== '0 || cyc != 2) begin
      miscompares++;
      $display("FAIL addi_single: got word=%h err=%b addr=%0d lat=%0d to=%b expected 00500093 0 0 2 0",
               w, e, a, cyc, to);
    end
  endtask

  task automatic test_back_to_back();
    do_clear();
    out_ready = 1'b1;
    @(negedge clk);
    set_req(mk(INSTR_SUB, 5'd3, 5'd1, 5'd2, 32'h0, 12'h0, 4'h0, 4'h0, 32'h0, 1'b0));
    req_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_ready: got %b expected 1", req_ready);
    end
    set_req(mk(INSTR_LUI, 5'd5, 5'd0, 5'd0, 32'h12345, 12'h0, 4'h0, 4'h0, 32'h0, 1'b0));
    @(negedge clk);
    req_valid = 1'b0;
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 32'h4020_81B3 || out_addr !== 10'd0 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_sub: got v=%b word=%h addr=%0d expected 1 402081b3 0", out_valid, out_word, out_addr);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_word !== 32'h1234_52B7 || out_addr !== 10'd1 || out_err !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_lui: got v=%b word=%h addr=%0d expected 1 123452b7 1", out_valid, out_word, out_addr);
    end
  endtask

  task automatic test_formats();
    vec_t tbl[20];
    logic [31:0] w; logic e; logic [AW-1:0] a; int cyc; bit to_i, to_o;
    tbl[0]  = mk(INSTR_BEQ,    5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 12'h0,   4'h0, 4'h0, 32'hFE20_8CE3, 1'b0);
    tbl[1]  = mk(INSTR_JAL,    5'd1, 5'd0, 5'd0, 32'd2048,      12'h0,   4'h0, 4'h0, 32'h0010_00EF, 1'b0);
    tbl[2]  = mk(INSTR_SRAI,   5'd2, 5'd3, 5'd4, 32'h0,         12'h0,   4'h0, 4'h0, 32'h4041_D113, 1'b0);
    tbl[3]  = mk(INSTR_CSRRWI, 5'd1, 5'd5, 5'd0, 32'h0,         12'h300, 4'h0, 4'h0, 32'h3002_D0F3, 1'b0);
    tbl[4]  = mk(INSTR_CSRRS,  5'd3, 5'd4, 5'd0, 32'h0,         12'hC00, 4'h0, 4'h0, 32'hC002_21F3, 1'b0);
    tbl[5]  = mk(INSTR_FENCE,  5'd7, 5'd9, 5'd0, 32'h0,         12'h0,   4'h3, 4'h3, 32'h0330_000F, 1'b0);
    tbl[6]  = mk(INSTR_FENCE_I,5'd0, 5'd0, 5'd0, 32'h0,         12'h0,   4'h0, 4'h0, 32'h0000_100F, 1'b0);
    tbl[7]  = mk(INSTR_ECALL,  5'd0, 5'd0, 5'd0, 32'h0,         12'h0,   4'h0, 4'h0, 32'h0000_0073, 1'b0);
    tbl[8]  = mk(INSTR_EBREAK, 5'd0, 5'd0, 5'd0, 32'h0,         12'h0,   4'h0, 4'h0, 32'h0010_0073, 1'b0);
    tbl[9]  = mk(INSTR_SW,     5'd0, 5'd2, 5'd5, 32'hFFFF_FFFC, 12'h0,   4'h0, 4'h0, 32'hFE51_2E23, 1'b0);
    tbl[10] = mk(INSTR_ADDI,   5'd0, 5'd0, 5'd0, 32'hFFFF_F800, 12'h0,   4'h0, 4'h0, 32'h8000_0013, 1'b0);
    tbl[11] = mk(INSTR_JAL,    5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 12'h0,   4'h0, 4'h0, 32'h8000_006F, 1'b0);
    tbl[12] = mk(INSTR_LW,     5'd6, 5'd2, 5'd0, 32'd2047,      12'h0,   4'h0, 4'h0, 32'h7FF1_2303, 1'b0);
    tbl[13] = mk(INSTR_BGEU,   5'd0, 5'd3, 5'd4, 32'd4094,      12'h0,   4'h0, 4'h0, 32'h7E41_FFE3, 1'b0);
    tbl[14] = mk(INSTR_JAL,    5'd1, 5'd0, 5'd0, 32'd1,         12'h0,   4'h0, 4'h0, NOP,           1'b1);
    tbl[15] = mk(INSTR_LUI,    5'd1, 5'd0, 5'd0, 32'h0010_0000, 12'h0,   4'h0, 4'h0, NOP,           1'b1);
    tbl[16] = mk(INSTR_BEQ,    5'd0, 5'd1, 5'd2, 32'd4096,      12'h0,   4'h0, 4'h0, NOP,           1'b1);
    tbl[17] = mk(INSTR_SLTI,   5'd1, 5'd1, 5'd0, 32'hFFFF_F7FF, 12'h0,   4'h0, 4'h0, NOP,           1'b1);
    tbl[18] = mk(INSTR_ADD,    5'd1, 5'd2, 5'd3, 32'hFFFF_FFFF, 12'h0,   4'h0, 4'h0, 32'h0031_00B3, 1'b0);
    tbl[19] = mk(INSTR_AUIPC,  5'd10,5'd0, 5'd0, 32'h000F_FFFF, 12'h0,   4'h0, 4'h0, 32'hFFFF_F517, 1'b0);
    do_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      issue(tbl[i], to_i);
      wait_out(w, e, a, cyc, to_o);
      vectors++;
      if (to_i || to_o || w !== tbl[i].word || e !== tbl[i].err || a !== AW'(i)) begin
        miscompares++;
        $display("FAIL format_%0d: got word=%h err=%b addr=%0d expected word=%h err=%b addr=%0d",
                 i, w, e, a, tbl[i].word, tbl[i].err, i);
      end
    end
  endtask

  task automatic test_errors();
    vec_t tbl[3];
    logic [31:0] w; logic e; logic [AW-1:0] a; int cyc; bit to_i, to_o;
    tbl[0] = mk(INSTR_ADDI,    5'd1, 5'd0, 5'd0, 32'd2048, 12'h0, 4'h0, 4'h0, NOP, 1'b1);
    tbl[1] = mk(INSTR_BNE,     5'd0, 5'd1, 5'd2, 32'd3,    12'h0, 4'h0, 4'h0, NOP, 1'b1);
    tbl[2] = mk(INSTR_INVALID, 5'd0, 5'd0, 5'd0, 32'h0,    12'h0, 4'h0, 4'h0, NOP, 1'b1);
    do_clear();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(tbl[i], to_i);
      wait_out(w, e, a, cyc, to_o);
      vectors++;
      if (to_i || to_o || w !== NOP || e !== 1'b1 || a !== AW'(i) || err_count !== EW'(i + 1)) begin
        miscompares++;
        $display("FAIL error_%0d: got word=%h err=%b addr=%0d cnt=%0d expected 00000013 1 %0d %0d",
                 i, w, e, a, err_count, i, i + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_w[3];
    logic [31:0] got_w[8];
    logic [AW-1:0] got_a[8];
    int n;
    bit c_hold, c_acc;
    exp_w[0] = 32'h0010_0093; exp_w[1] = 32'h0020_0113; exp_w[2] = 32'h0030_0193;
    do_clear();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      set_req(mk(INSTR_ADDI, 5'(i + 1), 5'd0, 5'd0, 32'(i + 1), 12'h0, 4'h0, 4'h0, 32'h0, 1'b0));
      req_valid = 1'b1;
      vectors++;
      if (req_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL bp_accept_%0d: got req_ready=%b expected 1", i, req_ready);
      end
    end
    @(negedge clk);
    set_req(mk(INSTR_ADDI, 5'd3, 5'd0, 5'd0, 32'd3, 12'h0, 4'h0, 4'h0, 32'h0, 1'b0));
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clk);
      vectors++;
      if (req_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== exp_w[0] || out_addr !== '0) begin
        miscompares++;
        $display("FAIL bp_hold_%0d: got ready=%b v=%b word=%h addr=%0d expected 0 1 %h 0",
                 i, req_ready, out_valid, out_word, out_addr, exp_w[0]);
      end
    end
    out_ready = 1'b1;
    #1;
    n = 0; c_hold = 1'b0; c_acc = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid) begin
        if (n < 8) begin got_w[n] = out_word; got_a[n] = out_addr; end
        n++;
      end
      if (c_hold) begin
        req_valid = 1'b0; c_hold = 1'b0; c_acc = 1'b1;
      end else if (req_valid && req_ready) begin
        c_hold = 1'b1;
      end
      @(negedge clk);
      #1;
    end
    req_valid = 1'b0;
    vectors++;
    if (n != 3 || !c_acc) begin
      miscompares++;
      $display("FAIL bp_count: got %0d words, third accepted=%b expected 3 and 1", n, c_acc);
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (i >= n || got_w[i] !== exp_w[i] || got_a[i] !== AW'(i)) begin
        miscompares++;
        $display("FAIL bp_order_%0d: got word=%h addr=%0d expected %h %0d",
                 i, (i < n) ? got_w[i] : 32'hx, (i < n) ? got_a[i] : AW'(0), exp_w[i], i);
      end
    end
  endtask

  task automatic test_reset_midflight();
    logic [31:0] w; logic e; logic [AW-1:0] a; int cyc; bit to;
    bit seen;
    out_ready = 1'b1;
    issue(mk(INSTR_INVALID, 5'd0, 5'd0, 5'd0, 32'h0, 12'h0, 4'h0, 4'h0, 32'h0, 1'b0), to);
    wait_out(w, e, a, cyc, to);
    out_ready = 1'b0;
    issue(mk(INSTR_ADDI, 5'd1, 5'd0, 5'd0, 32'd7, 12'h0, 4'h0, 4'h0, 32'h0, 1'b0), to);
    issue(mk(INSTR_ADDI, 5'd2, 5'd0, 5'd0, 32'd8, 12'h0, 4'h0, 4'h0, 32'h0, 1'b0), to);
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b1 || out_addr === '0 || err_count === '0) begin
      miscompares++;
      $display("FAIL rst_precond: got v=%b addr=%0d cnt=%0d expected 1 and nonzero counters",
               out_valid, out_addr, err_count);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || out_addr !== '0 || err_count !== '0 || out_word !== '0) begin
      miscompares++;
      $display("FAIL rst_midflight: got v=%b addr=%0d cnt=%0d word=%h expected all zero",
               out_valid, out_addr, err_count, out_word);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_no_output: got out_valid seen=%b expected 0", seen);
    end
  endtask

  task automatic test_clear();
    logic [31:0] w; logic e; logic [AW-1:0] a; int cyc; bit to;
    bit seen;
    out_ready = 1'b1;
    issue(mk(INSTR_ADDI, 5'd1, 5'd0, 5'd0, 32'd1, 12'h0, 4'h0, 4'h0, 32'h0, 1'b0), to);
    wait_out(w, e, a, cyc, to);
    out_ready = 1'b0;
    issue(mk(INSTR_ADDI, 5'd2, 5'd0, 5'd0, 32'd2, 12'h0, 4'h0, 4'h0, 32'h0, 1'b0), to);
    @(negedge clk);
    set_req(mk(INSTR_ADDI, 5'd3, 5'd0, 5'd0, 32'd3, 12'h0, 4'h0, 4'h0, 32'h0, 1'b0));
    req_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    req_valid = 1'b0;
    out_ready = 1'b1;
    vectors++;
    if (out_addr !== '0 || err_count !== '0 || out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL clear_state: got addr=%0d cnt=%0d v=%b expected 0 0 0", out_addr, err_count, out_valid);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || out_addr !== '0) begin
      miscompares++;
      $display("FAIL clear_no_accept: got out_valid seen=%b addr=%0d expected 0 0", seen, out_addr);
    end
  endtask

  task automatic test_saturation_wrap();
    int acc;
    do_clear();
    out_ready = 1'b1;
    @(negedge clk);
    set_req(mk(instr_kind_t'(6'd63), 5'd0, 5'd0, 5'd0, 32'h0, 12'h0, 4'h0, 4'h0, 32'h0, 1'b0));
    req_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 1030; i++) begin
      if (req_ready) acc++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    vectors++;
    if (acc != 1030 || out_addr !== AW'(6) || err_count !== '1) begin
      miscompares++;
      $display("FAIL sat_wrap: got accepts=%0d addr=%0d cnt=%0d expected 1030 6 255", acc, out_addr, err_count);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; req_valid = 1'b0; out_ready = 1'b1;
    req_kind = INSTR_INVALID; req_rd = '0; req_rs1 = '0; req_rs2 = '0;
    req_imm = '0; req_csr = '0; req_pred = '0; req_succ = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_formats();
    test_errors();
    test_backpressure();
    test_reset_midflight();
    test_clear();
    test_saturation_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
